// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, shared memory port, timeout trap.
// Optional macro RISCV_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap instead of executing as a NOP.
module riscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       bus_err,
  output logic       illegal,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_LOAD, C_STORE, C_ALUI, C_ALUR, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             tmo;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic             ill_q, ill_d;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  function automatic cls_e op_class(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_ALUI;
      7'b0110011: return C_ALUR;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  assign tmo     = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));
  assign bus_err = bus_err_q;
  assign state_o = state_q;

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    bus_err_d    = bus_err_q;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    ill_d        = ill_q;
`endif
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_DECODE: begin
        cls_d   = op_class(opcode);
        state_d = S_EXEC;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        if (cls_d == C_ILL) begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end
`endif
      end
      S_EXEC: begin
        alu_a_sel = cls_q inside {C_BRANCH, C_JAL, C_AUIPC};
        alu_b_sel = !(cls_q inside {C_ALUR, C_BRANCH});
        if (cls_q == C_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (cls_q inside {C_LOAD, C_STORE}) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        if (mem_rdy) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_WB: begin
        // Illegal opcodes only reach WB when they run as a NOP.
        rf_we   = (cls_q != C_ILL);
        wb_sel  = (cls_q == C_LOAD) ? 2'd1 : (cls_q inside {C_JAL, C_JALR}) ? 2'd2 : 2'd0;
        pc_we   = 1'b1;
        pc_sel  = (cls_q == C_JAL) ? 2'd1 : (cls_q == C_JALR) ? 2'd2 : 2'd0;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)          cnt_d = '0;
    else if (mem_req && !mem_rdy)    cnt_d = cnt_q + 1'b1;
    else                             cnt_d = cnt_q;

    // Architectural side effects are suppressed in the cycle reset is sampled.
    if (rst) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      rf_we  = 1'b0;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      ill_q     <= ill_d;
`endif
    end
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed and random instruction streams vs a per-instruction model.
module tb_riscv_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, retire;
  logic       bus_err, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state_o;

  riscv_mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .bus_err(bus_err),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       a_sel, b_sel, rf_we;
    logic [1:0] wb_sel;
    logic       retire, bus_err, illegal;
  } obs_t;

  obs_t obs;
  assign obs = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                alu_a_sel, alu_b_sel, rf_we, wb_sel, retire, bus_err, illegal};

  int n_chk  = 0;
  int n_fail = 0;

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at posedge+1: drive inputs, check outputs mid-cycle, advance one clock.
  task automatic cyc(input string tag, input obs_t e, input logic rdy, input logic br);
    mem_rdy  = rdy;
    br_taken = br;
    #2;
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", blank(3'd0), rb(), rb());
    rst = 1'b0;
    cyc("idle", blank(3'd0), rb(), rb());
  endtask

  // One instruction from FETCH to completion; fw/mw are wait cycles before mem_rdy.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic br,
                           input bit rst_in_wb, output bit trapped);
    bit   ld, st, ai, ar, bra, jal, jalr, lui, aui, ill;
    obs_t e;
    trapped = 1'b0;
    ld   = (op == 7'b0000011); st  = (op == 7'b0100011); ai   = (op == 7'b0010011);
    ar   = (op == 7'b0110011); bra = (op == 7'b1100011); jal  = (op == 7'b1101111);
    jalr = (op == 7'b1100111); lui = (op == 7'b0110111); aui  = (op == 7'b0010111);
    ill  = !(ld | st | ai | ar | bra | jal | jalr | lui | aui);
    opcode = op;
    for (int i = 0; i <= fw; i++) begin
      e = blank(3'd1); e.mem_req = 1'b1; e.ir_we = (i == fw);
      cyc("fetch", e, i == fw, rb());
    end
    cyc("decode", blank(3'd2), rb(), rb());
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    if (ill) begin
      e = blank(3'd6); e.illegal = 1'b1;
      for (int i = 0; i < 3; i++) cyc("illegal_trap", e, rb(), rb());
      trapped = 1'b1;
      return;
    end
`endif
    e = blank(3'd3);
    e.a_sel = bra | jal | aui;
    e.b_sel = !(ar | bra);
    if (bra) begin
      e.pc_we = 1'b1; e.pc_sel = {1'b0, br}; e.retire = 1'b1;
      cyc("exec_branch", e, rb(), br);
      return;
    end
    cyc("exec", e, rb(), br);
    if (ld | st) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st;
        if (i == mw && st) begin e.pc_we = 1'b1; e.retire = 1'b1; end
        cyc(st ? "mem_store" : "mem_load", e, i == mw, rb());
      end
      if (st) return;
    end
    e = blank(3'd5);
    e.rf_we  = !ill;
    e.wb_sel = ld ? 2'd1 : (jal | jalr) ? 2'd2 : 2'd0;
    e.pc_we  = 1'b1;
    e.pc_sel = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    e.retire = 1'b1;
    if (rst_in_wb) begin
      rst = 1'b1; e.rf_we = 1'b0; e.pc_we = 1'b0; e.retire = 1'b0;
    end
    cyc("wb", e, rb(), rb());
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

  initial begin
    bit   tr;
    obs_t e;
    do_reset();
    run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, tr);   // ALUR
    run_instr(7'b0000011, 0, 3, 1'b0, 1'b0, tr);   // LOAD, 3 MEM waits
    run_instr(7'b1100011, 0, 0, 1'b1, 1'b0, tr);   // BRANCH taken
    run_instr(7'b1100011, 2, 0, 1'b0, 1'b0, tr);   // BRANCH not taken
    run_instr(7'b1100111, 0, 0, 1'b0, 1'b0, tr);   // JALR
    run_instr(7'b0100011, 1, 2, 1'b0, 1'b0, tr);   // STORE
    run_instr(7'b0010011, 15, 0, 1'b0, 1'b0, tr);  // rdy on the last allowed FETCH cycle
    run_instr(7'b0000011, 15, 15, 1'b0, 1'b0, tr); // counter must restart on MEM entry
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, tr);   // illegal opcode
    if (tr) do_reset();

    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rb(), 1'b0, tr);
      if (tr) do_reset();
    end

    // Reset sampled in WB: no side effects, then IDLE.
    run_instr(7'b0110011, 1, 0, 1'b0, 1'b1, tr);
    cyc("rst_after_wb", blank(3'd0), rb(), rb());
    rst = 1'b0;
    cyc("idle_after_rst", blank(3'd0), rb(), rb());

    // FETCH timeout: 16 cycles without mem_rdy, then sticky bus error in TRAP.
    opcode = 7'b0110011;
    for (int i = 0; i < 16; i++) begin
      e = blank(3'd1); e.mem_req = 1'b1;
      cyc("fetch_wait", e, 1'b0, rb());
    end
    e = blank(3'd6); e.bus_err = 1'b1;
    for (int i = 0; i < 4; i++) cyc("timeout_trap", e, rb(), rb());
    do_reset();
    run_instr(7'b0010111, 0, 0, 1'b0, 1'b0, tr);   // AUIPC after recovery

    // MEM timeout on a load.
    opcode = 7'b0000011;
    e = blank(3'd1); e.mem_req = 1'b1; e.ir_we = 1'b1;
    cyc("fetch", e, 1'b1, rb());
    cyc("decode", blank(3'd2), rb(), rb());
    e = blank(3'd3); e.b_sel = 1'b1;
    cyc("exec", e, rb(), rb());
    for (int i = 0; i < 16; i++) begin
      e = blank(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1;
      cyc("mem_wait", e, 1'b0, rb());
    end
    e = blank(3'd6); e.bus_err = 1'b1;
    cyc("mem_timeout_trap", e, rb(), rb());
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
